t_flip_flop: RTL and testbench

Single-clock toggle flip-flop: each rising clock edge with the toggle input high inverts the stored state; with toggle low the state holds. It is a leaf storage cell, used directly as a divide-by-two stage or as the per-bit element of toggle counters and dividers. A `WIDTH` parameter scales it to a bank of independent toggle bits sharing one clock and reset; the default is a single bit.

---
 rtl/t_flip_flop_pkg.sv | 10 +
 rtl/t_flip_flop_bit.sv | 28 ++
 rtl/t_flip_flop.sv | 32 +++
 tb/tb_t_flip_flop.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/t_flip_flop_pkg.sv
// Shared constants for the toggle flip-flop bank.
// Width bounds and the default reset state.
package t_flip_flop_pkg;

    localparam int TFF_WIDTH_MIN = 1;
    localparam int TFF_WIDTH_MAX = 64;

    localparam logic [TFF_WIDTH_MAX-1:0] TFF_RESET_DEFAULT = '0;

endpackage

// File: rtl/t_flip_flop_bit.sv
// Single toggle bit: q inverts on a rising clk when t is high.
// Async active-low reset loads the supplied reset value.
module t_ff_bit (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rst_val,
    input  logic i_t,
    output logic o_q
);

    logic r_q;
    logic w_q_next;

    // Next state is the stored bit flipped by the toggle request.
    assign w_q_next = r_q ^ i_t;

    // State flop; reset forces the load value at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= i_rst_val;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops.
// Shared clock and async active-low reset; no inter-bit carry.
module t_flip_flop
    import t_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = TFF_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    // Reject out-of-range widths while elaborating.
    if (WIDTH < TFF_WIDTH_MIN || WIDTH > TFF_WIDTH_MAX) begin : g_bad_width
        $error("t_flip_flop: WIDTH=%0d outside %0d..%0d",
               WIDTH, TFF_WIDTH_MIN, TFF_WIDTH_MAX);
    end

    // One independent toggle cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_bit u_bit (
            .i_clk     (clk),
            .i_rst_n   (rst),
            .i_rst_val (RESET_VALUE[i]),
            .i_t       (t[i]),
            .o_q       (q[i])
        );
    end

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench for t_flip_flop (1-bit and 4-bit instances).
// Reference model counts toggle requests per bit; parity gives q.
module tb_t_flip_flop;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk;
    logic       rst;
    logic       t1;
    logic       q1;
    logic [3:0] t4;
    logic [3:0] q4;

    int checks   = 0;
    int failures = 0;

    int cnt1;
    int cnt4 [4];

    t_flip_flop u_dut1 (
        .t   (t1),
        .clk (clk),
        .rst (rst),
        .q   (q1)
    );

    t_flip_flop #(
        .WIDTH       (4),
        .RESET_VALUE (RV4)
    ) u_dut4 (
        .t   (t4),
        .clk (clk),
        .rst (rst),
        .q   (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp1();
        return (cnt1 % 2) == 1;
    endfunction

    function automatic logic [3:0] exp4();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i] = RV4[i] ^ ((cnt4[i] % 2) == 1);
        end
        return v;
    endfunction

    task automatic model_reset();
        cnt1 = 0;
        for (int i = 0; i < 4; i++) cnt4[i] = 0;
    endtask

    task automatic chk1(input string tag, input logic exp);
        checks++;
        assert (q1 === exp) else begin
            failures++;
            $error("FAIL %s q1 observed=%b expected=%b", tag, q1, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] exp);
        checks++;
        assert (q4 === exp) else begin
            failures++;
            $error("FAIL %s q4 observed=%b expected=%b", tag, q4, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk1(tag, exp1());
        chk4(tag, exp4());
    endtask

    // One rising edge: update model, then sample 1 unit later.
    task automatic edge_step(input logic a1, input logic [3:0] a4,
                             input string tag);
        t1 = a1;
        t4 = a4;
        @(posedge clk);
        if (rst) begin
            cnt1 += int'(a1);
            for (int i = 0; i < 4; i++) cnt4[i] += int'(a4[i]);
        end
        #1;
        chk_model(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        chk1(tag, 1'b0);
        chk4(tag, RV4);
    endtask

    logic       start1;
    logic [3:0] r4;

    initial begin
        rst = 1'b1;
        t1  = 1'b0;
        t4  = 4'h0;
        model_reset();

        // Reset mid-cycle before the first edge.
        #2;
        async_reset("reset_async");
        for (int k = 0; k < 3; k++) edge_step(1'b1, 4'hF, "reset_hold");
        chk1("reset_hold_zero", 1'b0);

        // Release between edges.
        rst = 1'b1;

        // Hold, single toggle, hold.
        for (int k = 0; k < 4; k++) edge_step(1'b0, 4'h0, "hold0");
        chk1("hold0_zero", 1'b0);
        edge_step(1'b1, 4'h0, "single_toggle");
        chk1("single_toggle_one", 1'b1);
        for (int k = 0; k < 4; k++) edge_step(1'b0, 4'h0, "hold1");
        chk1("hold1_one", 1'b1);

        // Back to 0, then a clk/2 run: 1,0,1,0.
        edge_step(1'b1, 4'h0, "to_zero");
        chk1("to_zero_val", 1'b0);
        edge_step(1'b1, 4'h0, "run_a");
        chk1("run_1", 1'b1);
        edge_step(1'b1, 4'h0, "run_b");
        chk1("run_0", 1'b0);
        edge_step(1'b1, 4'h0, "run_c");
        chk1("run_1b", 1'b1);
        edge_step(1'b1, 4'h0, "run_d");
        chk1("run_0b", 1'b0);

        // Five iterations of 2 hold + 4 toggle cycles.
        for (int it = 0; it < 5; it++) begin
            start1 = q1;
            for (int k = 0; k < 2; k++) edge_step(1'b0, 4'h0, "pat_hold");
            for (int k = 0; k < 4; k++) edge_step(1'b1, 4'h0, "pat_tog");
            chk1("pat_return", start1);
        end

        // Reset in the middle of a toggle run while q=1.
        edge_step(1'b1, 4'h0, "mid_a");
        if (q1 !== 1'b1) edge_step(1'b1, 4'h0, "mid_b");
        chk1("mid_pre_one", 1'b1);
        #2;
        async_reset("mid_reset");
        #2;
        rst = 1'b1;
        edge_step(1'b1, 4'h0, "mid_resume");
        chk1("mid_resume_one", 1'b1);

        // 4-bit directed: 1010 ^ 0110 = 1100, then hold.
        #2;
        async_reset("w4_reset");
        #2;
        rst = 1'b1;
        edge_step(1'b0, 4'b0110, "w4_toggle");
        chk4("w4_1100", 4'b1100);
        for (int k = 0; k < 3; k++) edge_step(1'b0, 4'h0, "w4_hold");
        chk4("w4_hold_1100", 4'b1100);

        // Randomized run with occasional mid-cycle resets.
        for (int k = 0; k < 300; k++) begin
            r4 = 4'($urandom);
            edge_step(1'($urandom), r4, "rand");
            if ($urandom_range(0, 29) == 0) begin
                #2;
                async_reset("rand_reset");
                #2;
                rst = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
